data_ram: RTL and testbench

Data memory that responds to the memory-stage RAM port (port A).
- Port A: byte-masked synchronous write, combinational read, so the memory stage can register read data at the same edge it presents the address.
- Port B: secondary req/ack port for a loader/debug master. It only uses cycles in which port A is not writing.
- Also provides a hardware clear sweep that zeroes the whole array.

---
 rtl/data_ram_if.sv | 26 ++
 rtl/data_ram.sv | 103 ++++++++++
 tb/tb_data_ram.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_if.sv
// Port A (memory stage) and port B (loader/debug req/ack) signal bundle for data_ram.
interface data_ram_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH/8-1:0] ram_we_a;
  logic [ADDR_WIDTH-1:0]   ram_addr_a;
  logic [DATA_WIDTH-1:0]   ram_wdata_a;
  logic [DATA_WIDTH-1:0]   ram_rdata_a;
  logic                    b_req;
  logic                    b_we;
  logic [ADDR_WIDTH-1:0]   b_addr;
  logic [DATA_WIDTH-1:0]   b_wdata;
  logic                    b_ack;
  logic [DATA_WIDTH-1:0]   b_rdata;

  modport master (
    output ram_we_a, ram_addr_a, ram_wdata_a, b_req, b_we, b_addr, b_wdata,
    input  ram_rdata_a, b_ack, b_rdata
  );

  modport slave (
    input  ram_we_a, ram_addr_a, ram_wdata_a, b_req, b_we, b_addr, b_wdata,
    output ram_rdata_a, b_ack, b_rdata
  );
endinterface

// File: rtl/data_ram.sv
// Byte-lane data memory: port A has absolute priority, port B and the clear
// sweep share whatever cycles port A leaves without a write.
module data_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  data_ram_if.slave      bus,
  input  logic           clr,
  output logic           clr_busy
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, ACK, CLEAR} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    a_wr, b_acc, sweep_wr;
  logic [NUM_LANES-1:0]    wr_be;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   b_rd_word;

  assign a_wr     = |bus.ram_we_a;
  // Gate with rst_n so a held request cannot slip a write in while the FSM is in reset.
  assign b_acc    = rst_n && (state == IDLE) && !clr && bus.b_req && !a_wr;
  assign sweep_wr = rst_n && (state == CLEAR) && !a_wr;

  always_comb begin
    wr_be   = '0;
    wr_addr = bus.ram_addr_a;
    wr_data = bus.ram_wdata_a;
    if (a_wr) begin
      wr_be = bus.ram_we_a;
    end else if (sweep_wr) begin
      wr_be   = '1;
      wr_addr = cnt;
      wr_data = '0;
    end else if (b_acc && bus.b_we) begin
      wr_be   = '1;
      wr_addr = bus.b_addr;
      wr_data = bus.b_wdata;
    end
  end

  // One single-write-port array per byte lane; contents are never reset.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_be[i]) lane_mem[wr_addr] <= wr_data[8*i +: 8];
    end

    assign bus.ram_rdata_a[8*i +: 8] = lane_mem[bus.ram_addr_a];
    assign b_rd_word[8*i +: 8]       = lane_mem[bus.b_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      clr_busy    <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.b_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.b_ack <= 1'b0;
          if (clr) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end else if (b_acc) begin
            state     <= ACK;
            bus.b_ack <= 1'b1;
            if (!bus.b_we) bus.b_rdata <= b_rd_word;
          end
        end
        ACK: begin
          bus.b_ack <= 1'b0;
          state     <= IDLE;
        end
        CLEAR: begin
          if (sweep_wr) begin
            cnt <= cnt + ADDR_WIDTH'(1);
            if (cnt == LAST) begin
              state    <= IDLE;
              clr_busy <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          bus.b_ack <= 1'b0;
          clr_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: byte writes, port B handshake, contention, clear sweep, reset.
module tb_data_ram;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic clr_busy;

  data_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  data_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr      (clr),
    .clr_busy (clr_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fillv(input int i);
    return 32'hA5A50000 + 32'(i);
  endfunction

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) begin
      bus.ram_we_a    = 4'hF;
      bus.ram_addr_a  = 9'(i);
      bus.ram_wdata_a = fillv(i);
      tick();
    end
    bus.ram_we_a = 4'h0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy_rise", {31'd0, clr_busy}, 32'd1);
  endtask

  task automatic b_xfer(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                        input int exp_lat, output logic [31:0] rd);
    int n;
    bus.b_req   = 1'b1;
    bus.b_we    = we;
    bus.b_addr  = addr;
    bus.b_wdata = wd;
    n = 0;
    while (bus.b_ack !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("b_latency", 32'(n), 32'(exp_lat));
    rd = bus.b_rdata;
    bus.b_req = 1'b0;
    tick();
    chk("b_ack_one_cycle", {31'd0, bus.b_ack}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] e;
    int n;

    vt[0] = '{4'hF,    9'd5, 32'h11223344, 1'b0, 32'h0};
    vt[1] = '{4'b0101, 9'd5, 32'hAABBCCDD, 1'b1, 32'h11223344};
    vt[2] = '{4'h0,    9'd5, 32'h0,        1'b1, 32'h11BB33DD};
    vt[3] = '{4'hF,    9'd6, 32'hFFFFFFFF, 1'b0, 32'h0};
    vt[4] = '{4'b1010, 9'd6, 32'h12345678, 1'b1, 32'hFFFFFFFF};
    vt[5] = '{4'h0,    9'd6, 32'h0,        1'b1, 32'h12FF56FF};
    vt[6] = '{4'h0,    9'd5, 32'h0,        1'b1, 32'h11BB33DD};
    vt[7] = '{4'b0001, 9'd5, 32'h000000EE, 1'b1, 32'h11BB33DD};
    vt[8] = '{4'h0,    9'd5, 32'h0,        1'b1, 32'h11BB33EE};

    bus.ram_we_a = '0; bus.ram_addr_a = '0; bus.ram_wdata_a = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b_ack",    {31'd0, bus.b_ack}, 32'd0);
    chk("rst_b_rdata",  bus.b_rdata, 32'd0);
    chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // port A byte-lane writes and same-cycle old-data reads
    for (int k = 0; k < 9; k++) begin
      bus.ram_we_a    = vt[k].we;
      bus.ram_addr_a  = vt[k].addr;
      bus.ram_wdata_a = vt[k].wdata;
      #1;
      if (vt[k].chk) chk($sformatf("vec%0d", k), bus.ram_rdata_a, vt[k].exp);
      tick();
    end
    bus.ram_we_a = 4'h0;

    // port B write, read back, rdata hold across a B write
    b_xfer(1'b1, 9'd3, 32'hDEADBEEF, 1, rd);
    b_xfer(1'b0, 9'd3, 32'h0, 1, rd);
    chk("b_read3", rd, 32'hDEADBEEF);
    bus.ram_addr_a = 9'd3;
    #1;
    chk("a_read3", bus.ram_rdata_a, 32'hDEADBEEF);
    b_xfer(1'b1, 9'd4, 32'h11111111, 1, rd);
    chk("b_rdata_hold", bus.b_rdata, 32'hDEADBEEF);

    // contention: A writes for 3 cycles, B read stalls
    bus.ram_we_a = 4'hF; bus.ram_addr_a = 9'd7; bus.ram_wdata_a = 32'h0000CAFE;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 9'd7;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("contend_no_ack", {31'd0, bus.b_ack}, 32'd0);
    end
    bus.ram_we_a = 4'h0;
    tick();
    chk("contend_ack", {31'd0, bus.b_ack}, 32'd1);
    chk("contend_rdata", bus.b_rdata, 32'h0000CAFE);
    bus.b_req = 1'b0;
    tick();

    // clear sweep, port A idle
    fill_all();
    pulse_clr();
    n = 0;
    while (clr_busy && n < 2000) begin tick(); n++; end
    chk("sweep_len", 32'(n), 32'd512);
    for (int i = 0; i < DEPTH; i++) begin
      bus.ram_addr_a = 9'(i);
      #1;
      chk("swept_zero", bus.ram_rdata_a, 32'd0);
    end

    // clear sweep with 10 A writes to already-swept words
    fill_all();
    pulse_clr();
    n = 0;
    while (clr_busy && n < 2000) begin
      if (n > 0 && n % 50 == 0 && n <= 500) begin
        bus.ram_we_a    = 4'hF;
        bus.ram_addr_a  = 9'(n / 10);
        bus.ram_wdata_a = 32'hBEEF0000 | 32'(n);
      end else begin
        bus.ram_we_a = 4'h0;
      end
      tick();
      n++;
    end
    bus.ram_we_a = 4'h0;
    chk("sweep_len_interleaved", 32'(n), 32'd522);
    for (int i = 0; i < DEPTH; i++) begin
      e = (i % 5 == 0 && i >= 5 && i <= 50) ? (32'hBEEF0000 | 32'(i * 10)) : 32'd0;
      bus.ram_addr_a = 9'(i);
      #1;
      chk("interleaved_word", bus.ram_rdata_a, e);
    end

    // simultaneous clr and b_req: clear wins, B completes after sweep
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 9'd9; bus.b_wdata = 32'h99999999;
    pulse_clr();
    chk("clr_wins_no_ack", {31'd0, bus.b_ack}, 32'd0);
    n = 0;
    while (bus.b_ack !== 1'b1 && n < 2000) begin tick(); n++; end
    chk("clr_then_b_lat", 32'(n), 32'd513);
    chk("ack_after_busy", {31'd0, clr_busy}, 32'd0);
    bus.b_req = 1'b0;
    tick();
    bus.ram_addr_a = 9'd9;
    #1;
    chk("b_write_after_clr", bus.ram_rdata_a, 32'h99999999);
    bus.ram_addr_a = 9'd8;
    #1;
    chk("neighbour_cleared", bus.ram_rdata_a, 32'd0);

    // reset mid-sweep at counter 100
    fill_all();
    pulse_clr();
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sweep_busy", {31'd0, clr_busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("busy_stays_low", {31'd0, clr_busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      e = (i < 100) ? 32'd0 : fillv(i);
      bus.ram_addr_a = 9'(i);
      #1;
      chk("partial_clear", bus.ram_rdata_a, e);
    end

    // reset mid-ACK; port A keeps working during reset
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 9'd200;
    tick();
    chk("pre_rst_ack", {31'd0, bus.b_ack}, 32'd1);
    chk("pre_rst_rdata", bus.b_rdata, fillv(200));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, bus.b_ack}, 32'd0);
    chk("rst_b_rdata_clr", bus.b_rdata, 32'd0);
    bus.b_req = 1'b0;
    bus.ram_we_a = 4'hF; bus.ram_addr_a = 9'd300; bus.ram_wdata_a = 32'h3000C0DE;
    tick();
    bus.ram_we_a = 4'h0;
    rst_n = 1'b1;
    #1;
    chk("a_write_in_reset", bus.ram_rdata_a, 32'h3000C0DE);
    b_xfer(1'b0, 9'd200, 32'h0, 1, rd);
    chk("b_reissue", rd, fillv(200));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
